// File: rtl/multi_chan_pwm_gen_pkg.sv
// Shared encodings for the multi-channel PWM generator.
// Mode and per-channel state definitions.
package pwm_pkg;

   typedef enum logic [1:0] {
      MODE_DIS     = 2'b00,
      MODE_CONT    = 2'b01,
      MODE_ONESHOT = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HIGH = 2'b01,
      ST_LOW  = 2'b10
   } state_e;

   function automatic logic mode_on(logic [1:0] m);
      return (m == MODE_CONT) || (m == MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/multi_chan_pwm_gen_if.sv
// Configuration write bus and sync strobe for the PWM generator.
// The master drives, the generator consumes.
interface multi_chan_pwm_gen_if #(
   parameter int N  = 8,
   parameter int CW = 2
);
   logic          wr_en;
   logic [CW-1:0] wr_ch;
   logic [N-1:0]  wr_m;
   logic [N-1:0]  wr_n;
   logic [1:0]    wr_mode;
   logic          sync;

   modport master (
      output wr_en, wr_ch, wr_m, wr_n, wr_mode, sync
   );

   modport slave (
      input wr_en, wr_ch, wr_m, wr_n, wr_mode, sync
   );
endinterface

// File: rtl/multi_chan_pwm_gen_chan.sv
// One PWM channel: IDLE/HIGH/LOW FSM, phase counter, shadow config.
// period end is predicted one clock early so it lines up with the last tick.
module pwm_chan
   import pwm_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick_i,
   input  logic         tick_nx_i,
   input  logic         sync_i,
   input  logic         wr_i,
   input  logic [N-1:0] m_i,
   input  logic [N-1:0] n_i,
   input  logic [1:0]   mode_i,
   output logic         pwm_o,
   output logic         pe_o
);

   state_e       st_q, st_d;
   mode_e        mode_q, mode_d, sh_mode_q, sh_mode_d;
   logic [N-1:0] cnt_q, cnt_d, m_q, m_d, n_q, n_d;
   logic [N-1:0] sh_m_q, sh_m_d, sh_n_q, sh_n_d;
   logic         sh_vld_q, sh_vld_d;
   logic         pwm_q, pwm_d, pe_q, pe_d;
   logic         wr_ok, bnd, ld;
   logic [N-1:0] nm, nn;
   mode_e        nmode;

   always_comb begin
      st_d      = st_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      m_d       = m_q;
      n_d       = n_q;
      sh_vld_d  = sh_vld_q;
      sh_m_d    = sh_m_q;
      sh_n_d    = sh_n_q;
      sh_mode_d = sh_mode_q;
      bnd       = 1'b0;
      ld        = 1'b0;
      wr_ok     = mode_on(mode_i) && ((m_i != '0) || (n_i != '0));

      // next-period source: fresh write, then pending shadow, then active
      if (wr_i) begin
         nm    = m_i;
         nn    = n_i;
         nmode = mode_e'(mode_i);
      end else if (sh_vld_q) begin
         nm    = sh_m_q;
         nn    = sh_n_q;
         nmode = sh_mode_q;
      end else begin
         nm    = m_q;
         nn    = n_q;
         nmode = mode_q;
      end

      if (wr_i && !wr_ok) begin
         st_d     = ST_IDLE;
         mode_d   = MODE_DIS;
         sh_vld_d = 1'b0;
      end else if ((wr_i && st_q == ST_IDLE) ||
                   (sync_i && st_q != ST_IDLE)) begin
         ld = 1'b1;
      end else if (st_q != ST_IDLE) begin
         if (wr_i) begin
            sh_vld_d  = 1'b1;
            sh_m_d    = m_i;
            sh_n_d    = n_i;
            sh_mode_d = mode_e'(mode_i);
         end
         if (tick_i) begin
            if (cnt_q != N'(1)) begin
               cnt_d = cnt_q - N'(1);
            end else if (st_q == ST_HIGH && n_q != '0) begin
               st_d  = ST_LOW;
               cnt_d = n_q;
            end else begin
               bnd = 1'b1;
            end
         end
         if (bnd) begin
            if (!wr_i && !sh_vld_q && mode_q == MODE_ONESHOT) begin
               st_d   = ST_IDLE;
               mode_d = MODE_DIS;
            end else begin
               ld = 1'b1;
            end
         end
      end

      if (ld) begin
         m_d      = nm;
         n_d      = nn;
         mode_d   = nmode;
         sh_vld_d = 1'b0;
         st_d     = (nm != '0) ? ST_HIGH : ST_LOW;
         cnt_d    = (nm != '0) ? nm : nn;
      end

      pwm_d = (st_d == ST_HIGH);
      pe_d  = tick_nx_i && (cnt_d == N'(1)) &&
              ((st_d == ST_LOW) || (st_d == ST_HIGH && n_d == '0));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q      <= ST_IDLE;
         mode_q    <= MODE_DIS;
         cnt_q     <= '0;
         m_q       <= '0;
         n_q       <= '0;
         sh_vld_q  <= 1'b0;
         sh_m_q    <= '0;
         sh_n_q    <= '0;
         sh_mode_q <= MODE_DIS;
         pwm_q     <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         st_q      <= st_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         m_q       <= m_d;
         n_q       <= n_d;
         sh_vld_q  <= sh_vld_d;
         sh_m_q    <= sh_m_d;
         sh_n_q    <= sh_n_d;
         sh_mode_q <= sh_mode_d;
         pwm_q     <= pwm_d;
         pe_q      <= pe_d;
      end
   end

   assign pwm_o = pwm_q;
   assign pe_o  = pe_q;

endmodule

// File: rtl/multi_chan_pwm_gen.sv
// Multi-channel PWM generator: shared prescaler, write decode, sync fan-out.
// Channels are independent pwm_chan instances.
module multi_chan_pwm_gen
   import pwm_pkg::*;
#(
   parameter int N   = 8,
   parameter int CH  = 4,
   parameter int DIV = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   multi_chan_pwm_gen_if.slave  bus,
   output logic [CH-1:0]        pwm_o,
   output logic [CH-1:0]        period_end_o
);

   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic          tick, tick_nx;

   // with DIV=1 the counter sits at 0 and tick stays high
   always_comb begin
      presc_d = presc_q + PW'(1);
      if (bus.sync || presc_q == PW'(DIV - 1)) presc_d = '0;
      tick    = (presc_q == PW'(DIV - 1));
      tick_nx = (presc_d == PW'(DIV - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) presc_q <= '0;
      else        presc_q <= presc_d;
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      pwm_chan #(
         .N(N)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .tick_i    (tick),
         .tick_nx_i (tick_nx),
         .sync_i    (bus.sync),
         .wr_i      (bus.wr_en && (bus.wr_ch == CW'(g))),
         .m_i       (bus.wr_m),
         .n_i       (bus.wr_n),
         .mode_i    (bus.wr_mode),
         .pwm_o     (pwm_o[g]),
         .pe_o      (period_end_o[g])
      );
   end

endmodule

// File: tb/tb_multi_chan_pwm_gen.sv
// Scoreboard bench for multi_chan_pwm_gen (N=4, CH=4, DIV=1).
// Expected waveforms come from an ideal period pattern per channel.
module tb_multi_chan_pwm_gen;
   import pwm_pkg::*;

   localparam int N   = 4;
   localparam int CH  = 4;
   localparam int DIV = 1;
   localparam int CW  = 2;

   typedef struct packed {
      logic [CH-1:0] pwm;
      logic [CH-1:0] pe;
   } exp_t;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic [CH-1:0] pwm_o;
   logic [CH-1:0] period_end_o;
   int            checks = 0;
   int            errors = 0;
   exp_t          exp_q[$];

   multi_chan_pwm_gen_if #(.N(N), .CW(CW)) bus ();

   multi_chan_pwm_gen #(
      .N(N), .CH(CH), .DIV(DIV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .pwm_o        (pwm_o),
      .period_end_o (period_end_o)
   );

   always #5 clk = ~clk;

   // ideal waveform k clocks after start: {pwm, period_end}
   function automatic logic [1:0] pat(int k, int m, int n);
      int p, r;
      if (k < 0 || m + n == 0) return 2'b00;
      p = m + n;
      r = k % p;
      return {(r < m), (r == p - 1)};
   endfunction

   function automatic exp_t put(exp_t e, int ch, logic [1:0] v);
      exp_t o;
      o = e;
      o.pwm[ch] = v[1];
      o.pe[ch]  = v[0];
      return o;
   endfunction

   task automatic idle_bus();
      bus.wr_en   = 1'b0;
      bus.wr_ch   = '0;
      bus.wr_m    = '0;
      bus.wr_n    = '0;
      bus.wr_mode = 2'b00;
      bus.sync    = 1'b0;
   endtask

   task automatic put_wr(int ch, int m, int n, logic [1:0] md);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = CW'(ch);
      bus.wr_m    = N'(m);
      bus.wr_n    = N'(n);
      bus.wr_mode = md;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_bus();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      idle_bus();
      #1;
      checks++;
      if (pwm_o !== '0 || period_end_o !== '0) begin
         errors++;
         $display("FAIL reset_init got pwm=%b pe=%b want 0000/0000",
                  pwm_o, period_end_o);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 2; c++) exp_q.push_back(put('0, 0, pat(c, 3, 3)));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0) put_wr(0, 3, 3, MODE_CONT);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL reset_pre c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (pwm_o !== '0 || period_end_o !== '0) begin
         errors++;
         $display("FAIL reset_async got pwm=%b pe=%b want 0000/0000",
                  pwm_o, period_end_o);
      end
      @(negedge clk);
      idle_bus();
      reset = 1'b1;
      for (int c = 0; c < 10; c++) exp_q.push_back('0);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL reset_quiet c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   task automatic test_continuous();
      exp_t e;
      do_reset();
      for (int c = 0; c < 18; c++) exp_q.push_back(put('0, 0, pat(c, 3, 3)));
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0) put_wr(0, 3, 3, MODE_CONT);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL cont c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   task automatic test_shadow();
      exp_t e;
      do_reset();
      for (int c = 0; c < 15; c++)
         exp_q.push_back(put('0, 0, (c < 6) ? pat(c, 3, 3) : pat(c - 6, 2, 1)));
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0) put_wr(0, 3, 3, MODE_CONT);
         if (c == 1) put_wr(0, 2, 1, MODE_CONT);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL shadow c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      for (int c = 0; c < 14; c++)
         exp_q.push_back(put('0, 0, (c < 6) ? pat(c, 3, 3) : pat(c - 6, 1, 2)));
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0) put_wr(0, 3, 3, MODE_CONT);
         if (c == 6) put_wr(0, 1, 2, MODE_CONT);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL b2b c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   task automatic test_boundary();
      exp_t e;
      do_reset();
      for (int c = 0; c < 42; c++) begin
         e = '0;
         e = put(e, 1, pat(c, 0, 5));
         e = put(e, 2, (c >= 1 && c < 35) ? pat(c - 1, 4, 0) : 2'b00);
         e = put(e, 3, pat(c - 2, 15, 15));
         exp_q.push_back(e);
      end
      for (int c = 0; c < 42; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0)  put_wr(1, 0, 5, MODE_CONT);
         if (c == 1)  put_wr(2, 4, 0, MODE_CONT);
         if (c == 2)  put_wr(3, 15, 15, MODE_CONT);
         if (c == 3)  put_wr(0, 0, 0, MODE_CONT);
         if (c == 35) put_wr(2, 0, 0, MODE_ONESHOT);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL bound c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   task automatic test_oneshot();
      exp_t       e;
      logic [1:0] v;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         v = 2'b00;
         if (c < 4)                v = pat(c, 2, 2);
         if (c == 10)              v = pat(0, 3, 3);
         if (c == 17 || c == 18)   v = pat(c - 17, 4, 4);
         exp_q.push_back(put('0, 3, v));
      end
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0)  put_wr(3, 2, 2, MODE_ONESHOT);
         if (c == 10) put_wr(3, 3, 3, MODE_CONT);
         if (c == 11) put_wr(3, 3, 3, 2'b00);
         if (c == 17) put_wr(3, 4, 4, MODE_CONT);
         if (c == 19) put_wr(3, 4, 4, 2'b11);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL oneshot c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   task automatic test_sync();
      exp_t e;
      do_reset();
      for (int c = 0; c < 32; c++) begin
         e = '0;
         if (c < 4)       e = put(e, 0, pat(c, 3, 3));
         else if (c < 20) e = put(e, 0, pat(c - 4, 3, 3));
         else             e = put(e, 0, pat(c - 20, 3, 3));
         if (c < 4)       e = put(e, 1, pat(c - 2, 1, 5));
         else if (c < 20) e = put(e, 1, pat(c - 4, 1, 5));
         else             e = put(e, 1, pat(c - 20, 2, 2));
         exp_q.push_back(e);
      end
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         idle_bus();
         if (c == 0) put_wr(0, 3, 3, MODE_CONT);
         if (c == 2) put_wr(1, 1, 5, MODE_CONT);
         if (c == 4) bus.sync = 1'b1;
         if (c == 20) begin
            put_wr(1, 2, 2, MODE_CONT);
            bus.sync = 1'b1;
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (pwm_o !== e.pwm || period_end_o !== e.pe) begin
            errors++;
            $display("FAIL sync c=%0d got pwm=%b pe=%b want pwm=%b pe=%b",
                     c, pwm_o, period_end_o, e.pwm, e.pe);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_continuous();
      test_shadow();
      test_back_to_back();
      test_boundary();
      test_oneshot();
      test_sync();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
